// File: rtl/piso_rr_sched.sv
// Round-robin scheduler sharing one DW-bit PISO shifter among NREQ requesters.
// Issues a one-cycle load/grant, then times DW serial cycles and flags the frame end.
module piso_rr_sched #(
    parameter int unsigned DW   = 4,
    parameter int unsigned NREQ = 4,
    parameter int unsigned SW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   data_flat,
    output logic [NREQ-1:0]      gnt,
    output logic                 piso_load,
    output logic [DW-1:0]        piso_data,
    output logic                 ser_valid,
    output logic [SW-1:0]        frame_src,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [1:0]      state;
    logic [SW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;

    logic            found;
    logic [SW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic [DW-1:0]   win_data;
    logic [SW-1:0]   rr_next;
    logic            last;
    logic            arb_edge;

    // First set request at or after rr_ptr, wrapping past NREQ-1.
    always_comb begin
        int unsigned idx;
        found    = 1'b0;
        win      = '0;
        win_oh   = '0;
        win_data = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && req[idx[SW-1:0]]) begin
                found              = 1'b1;
                win                = idx[SW-1:0];
                win_oh[idx[SW-1:0]] = 1'b1;
                win_data           = data_flat[idx*DW +: DW];
            end
        end
    end

    always_comb begin
        rr_next  = (win == SW'(NREQ - 1)) ? '0 : win + 1'b1;
        last     = (cnt == CW'(DW - 1));
        arb_edge = (state == IDLE) || ((state == SHIFT) && last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            gnt        <= '0;
            piso_load  <= 1'b0;
            piso_data  <= '0;
            ser_valid  <= 1'b0;
            frame_src  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt        <= '0;
            piso_load  <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (arb_edge && found) begin
                state     <= LOAD;
                gnt       <= win_oh;
                piso_load <= 1'b1;
                piso_data <= win_data;
                frame_src <= win;
                rr_ptr    <= rr_next;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: busy <= 1'b0;
                    LOAD: begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                    SHIFT: begin
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            ser_valid  <= 1'b1;
                            frame_done <= (cnt == CW'(DW - 2));
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_rr_sched.sv
// Randomized + directed bench for piso_rr_sched; a frame-level reference model
// feeds scoreboard queues that a negedge monitor drains and compares.
module tb_piso_rr_sched;

    localparam int DW   = 4;
    localparam int NREQ = 4;
    localparam int SW   = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  data_flat;
    logic [NREQ-1:0]     gnt;
    logic                piso_load;
    logic [DW-1:0]       piso_data;
    logic                ser_valid;
    logic [SW-1:0]       frame_src;
    logic                frame_done;
    logic                busy;

    piso_rr_sched #(.DW(DW), .NREQ(NREQ), .SW(SW)) dut (
        .clk(clk), .rst(rst), .req(req), .data_flat(data_flat),
        .gnt(gnt), .piso_load(piso_load), .piso_data(piso_data),
        .ser_valid(ser_valid), .frame_src(frame_src),
        .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int w; logic [DW-1:0] d; } grant_t;
    typedef struct { logic busy; logic load; logic sv; logic fd; int src; } cyc_t;

    grant_t gq[$];
    cyc_t   cq[$];

    int vec  = 0;
    int errs = 0;
    logic async_chk = 1'b0;
    logic final_chk = 1'b0;
    logic final_done = 1'b0;
    logic auto_drop  = 1'b1;

    // Reference model: a frame occupies DW+1 cycles after the winning edge;
    // the next arbitration happens when that budget runs out.
    int left  = 0;
    int rr    = 0;
    int lastw = 0;
    always @(posedge clk) begin
        bit g;
        int j;
        g = 1'b0;
        if (rst) begin
            left = 0; rr = 0; lastw = 0;
            gq.delete();
            cq.push_back('{busy: 1'b0, load: 1'b0, sv: 1'b0, fd: 1'b0, src: 0});
        end else begin
            if (left > 0) left--;
            if (left == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (rr + k) % NREQ;
                    if (!g && req[j]) begin
                        g     = 1'b1;
                        lastw = j;
                        gq.push_back('{w: j, d: data_flat[j*DW +: DW]});
                        rr    = (j + 1) % NREQ;
                        left  = DW + 1;
                    end
                end
            end
            cq.push_back('{busy: (left > 0), load: g, sv: (left >= 1 && left <= DW),
                           fd: (left == 1), src: lastw});
        end
    end

    function automatic void chk(string n, int a, int e);
        vec++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
        end
    endfunction

    always @(negedge clk or posedge async_chk) begin
        cyc_t   c;
        grant_t g;
        if (async_chk) begin
            chk("async_reset_outputs",
                int'({gnt, piso_load, piso_data, ser_valid, frame_src, frame_done, busy}), 0);
        end else begin
            if (cq.size() == 0) begin
                chk("cycle_queue_nonempty", 0, 1);
            end else begin
                c = cq.pop_front();
                chk("busy", int'(busy), int'(c.busy));
                chk("piso_load", int'(piso_load), int'(c.load));
                chk("ser_valid", int'(ser_valid), int'(c.sv));
                chk("frame_done", int'(frame_done), int'(c.fd));
                chk("frame_src", int'(frame_src), c.src);
            end
            if (piso_load) begin
                if (gq.size() == 0) begin
                    chk("grant_expected", 0, 1);
                end else begin
                    g = gq.pop_front();
                    chk("gnt", int'(gnt), 1 << g.w);
                    chk("piso_data", int'(piso_data), int'(g.d));
                end
            end else begin
                chk("gnt_idle", int'(gnt), 0);
            end
            if (final_chk && !final_done) begin
                final_done <= 1'b1;
                chk("grants_outstanding", gq.size(), 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (auto_drop)
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_async_chk();
        #1 async_chk = 1'b1;
        #1 async_chk = 1'b0;
    endtask

    task automatic do_reset();
        step();
        #1 rst = 1'b1;
        req = '0;
        pulse_async_chk();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        data_flat = '0;
        pulse_async_chk();
        step();
        step();
        rst = 1'b0;
        steps(2);

        // single requester, word 1010
        data_flat[0 +: DW] = 4'b1010;
        req = 4'b0001;
        steps(8);

        // all requesters held: grants rotate with no idle gap
        do_reset();
        auto_drop = 1'b0;
        data_flat = {4'hD, 4'hC, 4'hB, 4'hA};
        req = 4'b1111;
        steps(26);
        auto_drop = 1'b1;
        req = '0;
        steps(6);

        // wrap-around fairness after a grant to 2
        do_reset();
        data_flat = {4'h3, 4'h6, 4'h9, 4'hC};
        req = 4'b0100;
        step();
        req = 4'b0101;
        steps(16);

        // late request during a frame from 3 waits for the arbitration edge
        do_reset();
        req = 4'b1000;
        step();
        step();
        step();
        req[1] = 1'b1;
        steps(12);

        // asynchronous reset mid-frame, then lowest active index wins
        do_reset();
        req = 4'b0001;
        step();
        steps(3);
        #1 rst = 1'b1;
        pulse_async_chk();
        req = 4'b0110;
        step();
        rst = 1'b0;
        steps(14);

        // one-cycle pulse mid-frame is never granted
        do_reset();
        req = 4'b0100;
        step();
        step();
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        steps(8);

        // randomized traffic honouring the hold-until-grant handshake
        do_reset();
        auto_drop = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        if ($urandom_range(0, 3) == 0)
                            data_flat[i*DW +: DW] = DW'($urandom);
                        else
                            req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    data_flat[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        auto_drop = 1'b1;
        req = '0;
        steps(2 * (DW + 1) + 2);
        final_chk = 1'b1;
        steps(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
